// File: rtl/dllp_acknak_rx.sv
// ---------------------------------------------------------------------------
// dllp_acknak_rx
//
// Receive-side Ack/Nak DLLP processor sitting in front of the replay buffer.
// Three 16-bit words make one DLLP:
//   word0 = {type[7:0], byte1}
//   word1 = {rsvd[3:0], seq[11:0]}
//   word2 = CRC-16 (inverted remainder, poly 0x100B, init 0xFFFF)
// Good Ack/Nak DLLPs whose sequence number lies inside the outstanding window
// are forwarded as a one-cycle write strobe. The block also owns AckD_SEQ and
// REPLAY_NUM, and pulses retrain when REPLAY_NUM rolls over from 3 to 0.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   dllp_valid   dllp_data carries a DLLP word this cycle
//   dllp_sop     with dllp_valid, marks word0 of a DLLP
//   dllp_data    DLLP word
//   next_tx_seq  sequence number of the next TLP to be transmitted
//   tim_out      replay timer expiry pulse
//   we           one-cycle strobe to the replay buffer
//   ack_nak      01 ACK, 10 NAK, 00 when we is low
//   seq          AckNak_Seq_Num of the last forwarded DLLP
//   acked_seq    AckD_SEQ, last acknowledged sequence number
//   crc_err      one-cycle pulse, DLLP dropped for bad CRC
//   seq_err      one-cycle pulse, Ack/Nak dropped for out-of-window sequence
//   replay_num   current REPLAY_NUM
//   retrain      one-cycle pulse on REPLAY_NUM rollover
// ---------------------------------------------------------------------------
module dllp_acknak_rx (
    input  logic        clk,
    input  logic        reset,
    input  logic        dllp_valid,
    input  logic        dllp_sop,
    input  logic [15:0] dllp_data,
    input  logic [11:0] next_tx_seq,
    input  logic        tim_out,
    output logic        we,
    output logic [1:0]  ack_nak,
    output logic [11:0] seq,
    output logic [11:0] acked_seq,
    output logic        crc_err,
    output logic        seq_err,
    output logic [1:0]  replay_num,
    output logic        retrain
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2
    } state_t;

    localparam logic [7:0]  TYPE_ACK = 8'h00;
    localparam logic [7:0]  TYPE_NAK = 8'h10;
    localparam logic [15:0] CRC_POLY = 16'h100B;

    state_t      state;
    state_t      state_nxt;
    logic        capture_w0;
    logic        capture_w1;
    logic        frame_done;
    logic [15:0] word0;
    logic [15:0] word1;

    // Evaluation stage: the CRC compare and type decode are registered at
    // the word2 edge so the window check and state update get a full cycle.
    logic        ev_valid;
    logic        ev_crc_ok;
    logic        ev_is_ack;
    logic        ev_is_nak;
    logic [11:0] ev_seq;
    logic [11:0] ev_next_tx;

    logic [11:0] seq_dist;
    logic [11:0] seq_window;
    logic        in_window;
    logic        is_cmd;
    logic        ack_good;
    logic        nak_good;
    logic        bad_crc;
    logic        bad_seq;
    logic        replay_inc;

    // CRC-16 over word0 then word1, high byte first, each byte MSB first.
    // Walking the concatenation from bit 31 down gives exactly that order.
    // The returned value is the inverted remainder, i.e. the expected word2.
    function automatic logic [15:0] dllp_crc(input logic [31:0] data);
        logic [15:0] rem;
        rem = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            if (rem[15] ^ data[i]) begin
                rem = {rem[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                rem = {rem[14:0], 1'b0};
            end
        end
        return ~rem;
    endfunction

    // Frame assembly state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode. A sop always restarts a frame, whatever state we
    // are in, so a truncated DLLP is simply abandoned. Invalid cycles hold.
    always_comb begin
        state_nxt  = state;
        capture_w0 = 1'b0;
        capture_w1 = 1'b0;
        frame_done = 1'b0;
        if (dllp_valid) begin
            if (dllp_sop) begin
                capture_w0 = 1'b1;
                state_nxt  = W1;
            end else begin
                case (state)
                    IDLE: state_nxt = IDLE;
                    W1: begin
                        capture_w1 = 1'b1;
                        state_nxt  = W2;
                    end
                    W2: begin
                        frame_done = 1'b1;
                        state_nxt  = IDLE;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Word capture registers for the frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word0 <= 16'h0000;
            word1 <= 16'h0000;
        end else begin
            if (capture_w0) begin
                word0 <= dllp_data;
            end
            if (capture_w1) begin
                word1 <= dllp_data;
            end
        end
    end

    // Evaluation stage register, loaded when word2 arrives. next_tx_seq is
    // only looked at here, on the word2 cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_valid   <= 1'b0;
            ev_crc_ok  <= 1'b0;
            ev_is_ack  <= 1'b0;
            ev_is_nak  <= 1'b0;
            ev_seq     <= 12'h000;
            ev_next_tx <= 12'h000;
        end else begin
            ev_valid <= frame_done;
            if (frame_done) begin
                ev_crc_ok  <= (dllp_crc({word0, word1}) == dllp_data);
                ev_is_ack  <= (word0[15:8] == TYPE_ACK);
                ev_is_nak  <= (word0[15:8] == TYPE_NAK);
                ev_seq     <= word1[11:0];
                ev_next_tx <= next_tx_seq;
            end
        end
    end

    // Sequence window check, all modulo 4096: the received number must lie
    // between AckD_SEQ and next_tx_seq-1 inclusive. Measuring both distances
    // from AckD_SEQ makes the wrap at 4095->0 fall out of the subtraction.
    always_comb begin
        seq_dist   = ev_seq - acked_seq;
        seq_window = ev_next_tx - 12'd1 - acked_seq;
        in_window  = (seq_dist <= seq_window);
        is_cmd     = ev_valid & ev_crc_ok & (ev_is_ack | ev_is_nak);
        bad_crc    = ev_valid & ~ev_crc_ok;
        bad_seq    = is_cmd & ~in_window;
        ack_good   = is_cmd & in_window & ev_is_ack & (ev_seq != acked_seq);
        nak_good   = is_cmd & in_window & ev_is_nak;
        replay_inc = nak_good | tim_out;
    end

    // Result and link-state registers. A forward-progress ACK clears
    // REPLAY_NUM and overrides a coincident timer expiry; a NAK and a timer
    // expiry in the same cycle collapse into one increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we         <= 1'b0;
            ack_nak    <= 2'b00;
            seq        <= 12'h000;
            acked_seq  <= 12'hFFF;
            crc_err    <= 1'b0;
            seq_err    <= 1'b0;
            replay_num <= 2'd0;
            retrain    <= 1'b0;
        end else begin
            we      <= ack_good | nak_good;
            crc_err <= bad_crc;
            seq_err <= bad_seq;
            retrain <= 1'b0;
            if (ack_good) begin
                ack_nak <= 2'b01;
            end else if (nak_good) begin
                ack_nak <= 2'b10;
            end else begin
                ack_nak <= 2'b00;
            end
            if (ack_good | nak_good) begin
                seq       <= ev_seq;
                acked_seq <= ev_seq;
            end
            if (ack_good) begin
                replay_num <= 2'd0;
            end else if (replay_inc) begin
                replay_num <= replay_num + 2'd1;
                retrain    <= (replay_num == 2'd3);
            end
        end
    end

endmodule

// File: tb/tb_dllp_acknak_rx.sv
// ---------------------------------------------------------------------------
// tb_dllp_acknak_rx
//
// Drives directed scenarios followed by randomized DLLP traffic into
// dllp_acknak_rx and checks every output on every falling edge against a
// frame-level behavioural model, plus literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_dllp_acknak_rx;

    localparam int K_BAD   = 0;
    localparam int K_ACK   = 1;
    localparam int K_NAK   = 2;
    localparam int K_OTHER = 3;

    logic        clk;
    logic        reset;
    logic        dllp_valid;
    logic        dllp_sop;
    logic [15:0] dllp_data;
    logic [11:0] next_tx_seq;
    logic        tim_out;
    logic        we;
    logic [1:0]  ack_nak;
    logic [11:0] seq;
    logic [11:0] acked_seq;
    logic        crc_err;
    logic        seq_err;
    logic [1:0]  replay_num;
    logic        retrain;

    int vectors     = 0;
    int miscompares = 0;
    bit rand_mode   = 1'b0;

    // Behavioural model state
    logic        m_we;
    logic [1:0]  m_an;
    logic [11:0] m_seq;
    logic [11:0] m_acked;
    logic        m_crc;
    logic        m_serr;
    int          m_rn;
    logic        m_rt;
    logic [15:0] frame[$];
    bit          pend_valid;
    int          pend_kind;
    int          pend_seq;
    int          pend_ntx;

    dllp_acknak_rx dut (
        .clk         (clk),
        .reset       (reset),
        .dllp_valid  (dllp_valid),
        .dllp_sop    (dllp_sop),
        .dllp_data   (dllp_data),
        .next_tx_seq (next_tx_seq),
        .tim_out     (tim_out),
        .we          (we),
        .ack_nak     (ack_nak),
        .seq         (seq),
        .acked_seq   (acked_seq),
        .crc_err     (crc_err),
        .seq_err     (seq_err),
        .replay_num  (replay_num),
        .retrain     (retrain)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference CRC: byte list, each byte MSB first, inverted remainder.
    function automatic logic [15:0] model_crc(input logic [15:0] w0, input logic [15:0] w1);
        logic [7:0]  bytes [4];
        logic [15:0] r;
        logic        fb;
        bytes[0] = w0[15:8];
        bytes[1] = w0[7:0];
        bytes[2] = w1[15:8];
        bytes[3] = w1[7:0];
        r = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[15] ^ bytes[k][b];
                r  = r << 1;
                if (fb) r = r ^ 16'h100B;
            end
        end
        return ~r;
    endfunction

    function automatic bit in_window(input int s, input int ntx, input int a);
        int d;
        int w;
        d = (s - a + 4096) % 4096;
        w = (ntx - 1 - a + 8192) % 4096;
        return d <= w;
    endfunction

    task automatic model_reset();
        m_we = 1'b0; m_an = 2'b00; m_seq = 12'h000; m_acked = 12'hFFF;
        m_crc = 1'b0; m_serr = 1'b0; m_rn = 0; m_rt = 1'b0;
        frame.delete();
        pend_valid = 1'b0;
    endtask

    // One clock of the model: resolve the DLLP completed last edge, apply
    // the timer, then account for the word presented this edge.
    task automatic model_step();
        bit          ack_fwd;
        bit          inc;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        m_we = 1'b0; m_an = 2'b00; m_crc = 1'b0; m_serr = 1'b0; m_rt = 1'b0;
        ack_fwd = 1'b0;
        inc     = 1'b0;
        if (pend_valid) begin
            pend_valid = 1'b0;
            if (pend_kind == K_BAD) begin
                m_crc = 1'b1;
            end else if (pend_kind == K_ACK || pend_kind == K_NAK) begin
                if (!in_window(pend_seq, pend_ntx, int'(m_acked))) begin
                    m_serr = 1'b1;
                end else if (pend_kind == K_NAK || pend_seq != int'(m_acked)) begin
                    m_we    = 1'b1;
                    m_an    = (pend_kind == K_ACK) ? 2'b01 : 2'b10;
                    m_seq   = 12'(pend_seq);
                    m_acked = 12'(pend_seq);
                    if (pend_kind == K_ACK) ack_fwd = 1'b1;
                    else inc = 1'b1;
                end
            end
        end
        if (tim_out) inc = 1'b1;
        if (ack_fwd) begin
            m_rn = 0;
        end else if (inc) begin
            if (m_rn == 3) m_rt = 1'b1;
            m_rn = (m_rn + 1) % 4;
        end
        if (dllp_valid) begin
            if (dllp_sop) begin
                frame.delete();
                frame.push_back(dllp_data);
            end else if (frame.size() > 0) begin
                frame.push_back(dllp_data);
                if (frame.size() == 3) begin
                    w0 = frame[0];
                    w1 = frame[1];
                    w2 = frame[2];
                    if (model_crc(w0, w1) != w2) pend_kind = K_BAD;
                    else if (w0[15:8] == 8'h00) pend_kind = K_ACK;
                    else if (w0[15:8] == 8'h10) pend_kind = K_NAK;
                    else pend_kind = K_OTHER;
                    pend_seq   = int'(w1[11:0]);
                    pend_ntx   = int'(next_tx_seq);
                    pend_valid = 1'b1;
                    frame.delete();
                end
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // Full-output comparison on every falling edge.
    always @(negedge clk) begin
        logic [31:0] got;
        logic [31:0] exp;
        got = {we, ack_nak, seq, acked_seq, crc_err, seq_err, replay_num, retrain};
        exp = {m_we, m_an, m_seq, m_acked, m_crc, m_serr, 2'(m_rn), m_rt};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL model_cycle t=%0t actual=%h expected=%h", $time, got, exp);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then return just after the sampling edge.
    task automatic applyStimulus(input logic v, input logic s, input logic [15:0] d,
                                 input logic [11:0] ntx, input logic tim);
        dllp_valid  = v;
        dllp_sop    = s;
        dllp_data   = d;
        next_tx_seq = ntx;
        tim_out     = tim;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rand_tim();
        return rand_mode ? ($urandom_range(0, 9) == 0) : 1'b0;
    endfunction

    task automatic gaps();
        int n;
        n = rand_mode ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0) : 0;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'(
            $urandom), 12'($urandom), rand_tim());
    endtask

    task automatic sendFrame(input logic [7:0] typ, input logic [11:0] s,
                             input logic [11:0] ntx, input logic [15:0] flip);
        logic [15:0] w0;
        logic [15:0] w1;
        w0 = {typ, rand_mode ? 8'($urandom) : 8'h00};
        w1 = {rand_mode ? 4'($urandom) : 4'h0, s};
        applyStimulus(1'b1, 1'b1, w0, rand_mode ? 12'($urandom) : 12'h000, rand_tim());
        gaps();
        applyStimulus(1'b1, 1'b0, w1, rand_mode ? 12'($urandom) : 12'h000, rand_tim());
        gaps();
        applyStimulus(1'b1, 1'b0, model_crc(w0, w1) ^ flip, ntx, rand_tim());
    endtask

    task automatic idle(input logic [11:0] ntx);
        applyStimulus(1'b0, 1'b0, 16'h0000, ntx, 1'b0);
    endtask

    initial begin
        logic [7:0]  typ;
        logic [11:0] s;
        logic [11:0] ntx;
        logic [15:0] flip;
        dllp_valid = 1'b0; dllp_sop = 1'b0; dllp_data = 16'h0000;
        next_tx_seq = 12'h000; tim_out = 1'b0; reset = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("rst_acked", 32'(acked_seq), 32'hFFF);
        checkOutput("rst_replay", 32'(replay_num), 0);
        checkOutput("rst_we", 32'(we), 0);
        checkOutput("rst_seq", 32'(seq), 0);

        // Good ACK then NAK then duplicate ACK
        sendFrame(8'h00, 12'd3, 12'd5, 16'h0); idle(12'd5);
        checkOutput("ack3_we", 32'(we), 1);
        checkOutput("ack3_type", 32'(ack_nak), 1);
        checkOutput("ack3_seq", 32'(seq), 3);
        checkOutput("ack3_acked", 32'(acked_seq), 3);
        idle(12'd5);
        checkOutput("ack3_we_drop", 32'(we), 0);
        checkOutput("ack3_type_drop", 32'(ack_nak), 0);
        sendFrame(8'h10, 12'd3, 12'd5, 16'h0); idle(12'd5);
        checkOutput("nak3_type", 32'(ack_nak), 2);
        checkOutput("nak3_replay", 32'(replay_num), 1);
        sendFrame(8'h00, 12'd3, 12'd5, 16'h0); idle(12'd5);
        checkOutput("dup_we", 32'(we), 0);
        checkOutput("dup_replay", 32'(replay_num), 1);

        // Corrupt CRC
        sendFrame(8'h00, 12'd4, 12'd5, 16'h0001); idle(12'd5);
        checkOutput("crc_err", 32'(crc_err), 1);
        checkOutput("crc_we", 32'(we), 0);
        checkOutput("crc_acked", 32'(acked_seq), 3);

        // Window wrap
        sendFrame(8'h00, 12'd4094, 12'd4095, 16'h0); idle(12'd0);
        checkOutput("ack4094_acked", 32'(acked_seq), 4094);
        checkOutput("ack4094_replay", 32'(replay_num), 0);
        sendFrame(8'h00, 12'd1, 12'd2, 16'h0); idle(12'd0);
        checkOutput("wrap_we", 32'(we), 1);
        checkOutput("wrap_acked", 32'(acked_seq), 1);
        sendFrame(8'h00, 12'd2, 12'd2, 16'h0); idle(12'd0);
        checkOutput("range_seq_err", 32'(seq_err), 1);
        checkOutput("range_we", 32'(we), 0);
        checkOutput("range_acked", 32'(acked_seq), 1);

        // Timer expiries and rollover
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 12'd2, 1'b1);
            checkOutput("tim_replay", 32'(replay_num), 32'(i % 4));
            checkOutput("tim_retrain", 32'(retrain), (i == 4) ? 32'd1 : 32'd0);
        end
        sendFrame(8'h10, 12'd1, 12'd2, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 12'd2, 1'b1);
        checkOutput("naktim_we", 32'(we), 1);
        checkOutput("naktim_replay", 32'(replay_num), 1);

        // Sop restart after word1
        applyStimulus(1'b1, 1'b1, 16'h1000, 12'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0001, 12'd0, 1'b0);
        sendFrame(8'h00, 12'd4, 12'd10, 16'h0); idle(12'd0);
        checkOutput("restart_type", 32'(ack_nak), 1);
        checkOutput("restart_acked", 32'(acked_seq), 4);
        checkOutput("restart_replay", 32'(replay_num), 0);

        // Gaps inside a frame
        applyStimulus(1'b1, 1'b1, 16'h0000, 12'd0, 1'b0);
        idle(12'd0); idle(12'd0);
        applyStimulus(1'b1, 1'b0, 16'h0006, 12'd0, 1'b0);
        idle(12'd0); idle(12'd0);
        applyStimulus(1'b1, 1'b0, model_crc(16'h0000, 16'h0006), 12'd10, 1'b0);
        idle(12'd0);
        checkOutput("gap_we", 32'(we), 1);
        checkOutput("gap_acked", 32'(acked_seq), 6);

        // Reset while in W2
        applyStimulus(1'b1, 1'b1, 16'h0000, 12'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0009, 12'd0, 1'b0);
        dllp_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("midrst_acked", 32'(acked_seq), 32'hFFF);
        checkOutput("midrst_seq", 32'(seq), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sendFrame(8'h00, 12'd2, 12'd5, 16'h0); idle(12'd5);
        checkOutput("postrst_seq", 32'(seq), 2);
        checkOutput("postrst_acked", 32'(acked_seq), 2);

        // Randomized traffic
        rand_mode = 1'b1;
        for (int f = 0; f < 400; f++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: typ = 8'h00;
                5, 6, 7:       typ = 8'h10;
                default:       typ = 8'($urandom);
            endcase
            s    = m_acked + 12'($urandom_range(0, 10));
            ntx  = ($urandom_range(0, 7) == 0) ? 12'($urandom)
                                               : m_acked + 12'($urandom_range(1, 9));
            flip = ($urandom_range(0, 6) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            if ($urandom_range(0, 19) == 0) begin
                applyStimulus(1'b1, 1'b1, 16'($urandom), 12'($urandom), rand_tim());
                if ($urandom_range(0, 1) == 1)
                    applyStimulus(1'b1, 1'b0, 16'($urandom), 12'($urandom), rand_tim());
            end
            if ($urandom_range(0, 9) == 0)
                applyStimulus(1'b1, 1'b0, 16'($urandom), 12'($urandom), rand_tim());
            sendFrame(typ, s, ntx, flip);
            gaps();
        end
        rand_mode = 1'b0;
        repeat (3) idle(12'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dllp_acknak_rx.md
# dllp_acknak_rx

Receive-side Ack/Nak DLLP processor for the data link layer, directly upstream of the replay buffer. It assembles 16-bit DLLP words from the physical-layer receive path, checks the DLLP CRC-16 and validates the AckNak sequence number against outstanding TLPs. Good Ack/Nak commands are forwarded to the replay buffer as a one-cycle `we` strobe with `ack_nak` and `seq`. The block also tracks REPLAY_NUM and flags link retrain on rollover.

## Interface
- No parameters. DLLP length is fixed at 3 words and sequence width at 12 bits.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `dllp_valid` input 1: `dllp_data` carries a DLLP word this cycle.
- `dllp_sop` input 1: with `dllp_valid`, marks word0 of a DLLP.
- `dllp_data` input 16: word0 = {type[7:0], byte1}; word1 = {rsvd[3:0], seq[11:0]}; word2 = CRC-16.
- `next_tx_seq` input 12: sequence number the transmitter will assign to its next TLP.
- `tim_out` input 1: replay timer expiry pulse.
- `we` output 1: one-cycle strobe; `ack_nak`/`seq` valid to the replay buffer.
- `ack_nak` output 2: 00 none, 01 ACK, 10 NAK; 11 never driven.
- `seq` output 12: AckNak_Seq_Num of the forwarded DLLP.
- `acked_seq` output 12: last acknowledged sequence number (AckD_SEQ).
- `crc_err` output 1: one-cycle pulse; DLLP discarded for bad CRC.
- `seq_err` output 1: one-cycle pulse; Ack/Nak discarded, sequence out of range.
- `replay_num` output 2: current REPLAY_NUM.
- `retrain` output 1: one-cycle pulse on REPLAY_NUM rollover 3→0.

## Operation
- FSM states:
  - IDLE: a word with `dllp_valid & dllp_sop` is captured as word0, then the FSM moves to W1.
  - W1: a valid non-sop word is captured as word1, then the FSM moves to W2.
  - W2: a valid non-sop word is taken as CRC. The DLLP is evaluated and the FSM returns to IDLE.
- `dllp_valid` low in any state: state holds (gaps allowed).
- `dllp_valid & dllp_sop` in W1 or W2: the partial DLLP is dropped silently and the word is captured as a new word0. Next state is W1.
- In IDLE, a valid word without sop is ignored.
- CRC rule:
  - Polynomial 0x100B, initial value 0xFFFF.
  - Bytes are processed in the order word0[15:8], word0[7:0], word1[15:8], word1[7:0], each byte MSB first.
  - Expected word2 = bitwise inverse of the final remainder.
  - On mismatch, `crc_err` pulses for any DLLP type and there is no other effect.
- Type decode after a good CRC: 8'h00 = ACK, 8'h10 = NAK. Any other type is dropped with no pulse.
- Range check (all arithmetic modulo 4096, A = `acked_seq`, S = received seq): valid iff (S−A) ≤ (`next_tx_seq`−1−A).
- If the range check fails: `seq_err` pulses; no other effect.
- Valid ACK with S≠A: `we`=1, `ack_nak`=01, `seq`=S, `acked_seq`←S, `replay_num`←0.
- Valid ACK with S==A (duplicate): no output and no state change.
- Valid NAK (S==A allowed): `we`=1, `ack_nak`=10, `seq`=S, `acked_seq`←S, `replay_num` increments.
- `tim_out`: `replay_num` increments.
- NAK and `tim_out` in the same cycle: a single increment.
- Forward-progress ACK and `tim_out` in the same cycle: the reset to 0 wins.
- `replay_num` at 3 and incremented: wraps to 0 and `retrain` pulses.
- `ack_nak` is 00 whenever `we`=0. `seq` holds its last forwarded value.

## Timing
- Reset values:
  - FSM in IDLE.
  - `we`=0, `ack_nak`=00, `seq`=0, `crc_err`=0, `seq_err`=0, `retrain`=0, `replay_num`=0.
  - `acked_seq`=12'hFFF, so the first TLP (seq 0) is outstanding.
- Latency: word2 accepted on edge N; `we`/`crc_err`/`seq_err` are high for exactly cycle N+1. `acked_seq` and `replay_num` are updated at edge N+1.
- `retrain` asserts in the same cycle as the update that causes rollover.
- Back-to-back DLLPs: one result per 3 valid words, with no dead cycle required.
- `next_tx_seq` is sampled on the word2 cycle only.
- Reset asserted mid-frame: the partial DLLP is lost and all outputs return to reset values immediately.

## Test plan
- After reset, `next_tx_seq`=5, good ACK seq=3 -> `we` pulse one cycle, `ack_nak`=01, `seq`=3, `acked_seq`=3, `replay_num`=0.
- Then a good NAK seq=3 -> `we`, `ack_nak`=10, `seq`=3, `replay_num`=1. Repeat the same ACK seq=3 -> no `we`.
- Corrupt CRC (flip word2 bit 0) on ACK seq=4 -> `crc_err` one cycle, no `we`, `acked_seq` stays 3.
- `acked_seq`=4094, `next_tx_seq`=2: ACK seq=1 is accepted (wrap). ACK seq=2 -> `seq_err`, no `we`.
- Four `tim_out` pulses with no ACK -> `replay_num` 1,2,3,0; `retrain` pulses on the 4th. NAK coincident with `tim_out` -> increments once.
- Sop mid-frame after word1, gaps of 2 invalid cycles inside a frame, and reset asserted in W2 -> restart, held state, and reset values respectively. The good frame that follows is processed normally.
